instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer end of the instruction/opcode interface: owns the PC, fetches 32-bit RV32 instruction words from instruction memory and presents them in order to the control/decode stage.
- Decouples memory latency from decode with a small in-order fetch queue.
- Accepts branch redirects from execute and discards wrong-path words.
- Tags each word whose opcode is outside the four classes the control unit decodes.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- DEPTH, 2, fetch-queue entries; also the cap on in-flight plus buffered words (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  word-aligned fetch address (current PC).
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  decode-side word valid.
- inst  out  32  instruction word; bits [6:0] are the opcode.
- inst_pc  out  XLEN  PC of the instruction word.
- inst_illegal  out  1  opcode not in {0110011, 0000011, 0100011, 1100011}.
- inst_ready  in  1  decode accepts the word.
- redirect_valid  in  1  taken branch resolved (Branch & zero).
- redirect_pc  in  XLEN  branch target.

Behaviour:
- Reset (asynchronous, active-high). While rst is high and after release:
  - pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, inst_valid = 0, inst_illegal = 0, inst = 0, inst_pc = 0.
  - Reset mid-transaction abandons everything, including accepted-but-unanswered requests. The memory side must also be reset.
- Issue rule: imem_req_valid = !redirect_valid && (outstanding + count + drop_cnt < DEPTH). Here count is the number of queued words.
- Request handshake (imem_req_valid && imem_req_ready):
  - outstanding += 1.
  - Request PC is pushed into an in-order tag queue.
  - pc += 4, wrapping modulo 2^XLEN.
- Response handling:
  - If drop_cnt > 0: the word is discarded, drop_cnt -= 1, and its tag is popped.
  - Otherwise: {tag_pc, word} is pushed into the fetch queue and outstanding -= 1.
- Output: the queue head drives inst, inst_pc and inst_illegal. It is registered, with no combinational path from imem_rsp to inst. Minimum latency from request acceptance to inst_valid is 2 cycles with a 1-cycle memory.
- Decode handshake (inst_valid && inst_ready) pops the head.
- Full queue: no new request is issued, so no response can arrive into a full queue. A response arriving into a full queue is a protocol error; the response is dropped and a simulation assertion fires.
- Empty queue with a response in the same cycle: the word becomes visible on inst the next cycle (no bypass).
- Redirect (redirect_valid = 1), which has priority over every other event:
  - The fetch queue is flushed next cycle.
  - pc = {redirect_pc[XLEN-1:2], 2'b00}; low bits are ignored.
  - drop_cnt = outstanding minus any non-dropped response completing this cycle; those in-flight words are wrong-path. outstanding is cleared into drop_cnt.
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - Decode handshake and redirect in the same cycle: the handed-off word counts as consumed; the rest are flushed.
  - Redirect while drop_cnt > 0: drop_cnt accumulates.
- Back-to-back redirects: the last one wins.
- inst_illegal is computed at enqueue from word[6:0].
- Invariant: outstanding + drop_cnt + count <= DEPTH at all times.

Decomposition:
- Shared package holds:
  - Opcode constants OPC_RTYPE = 7'b0110011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011. The control unit uses the same constants.
  - XLEN default and the PC increment constant (4).
- One sub-module, fetch_queue: synchronous FIFO with parameters DEPTH and WIDTH (XLEN+33), push/pop/flush, count/full/empty outputs, asynchronous active-high reset.

Test Plan:
- Reset release, 1-cycle memory, inst_ready = 1 → requests at 0x0, 0x4, 0x8…; first inst_valid 2 cycles after the first accept; inst_pc = 0x0, then 0x4.
- inst_ready held low for 10 cycles → exactly DEPTH = 2 requests issued, then imem_req_valid = 0; on release, words come out in order 0x0, 0x4 with no loss or duplication.
- Redirect to 0x100 while 2 requests are outstanding → both responses discarded; next inst_pc = 0x100; no word from 0x8/0xC ever appears.
- Word 32'h0000_0013 (opcode 0010011) → inst_illegal = 1; word 32'h0000_0033 → inst_illegal = 0.
- redirect_pc = 0x103 → fetch address 0x100. PC at 0xFFFF_FFFC increments to 0x0000_0000.
- rst asserted asynchronously mid-burst → all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Constants shared by the fetch unit and the control-unit decoder.
// The opcode list defines which instruction classes the decoder understands.
package instr_fetch_unit_pkg;

   localparam int XLEN_DEF = 32;
   localparam int PC_INC   = 4;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   function automatic logic opc_illegal(input logic [6:0] opc);
      return !(opc == OPC_RTYPE || opc == OPC_LOAD || opc == OPC_STORE || opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Small synchronous FIFO used for both the fetch queue and the in-flight PC tag queue.
// The head entry is read straight out of the storage registers.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             flush,
   input  logic [WIDTH-1:0]                 din,
   output logic [WIDTH-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             full,
   output logic                             empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order fetches and queues returned words for decode.
// Branch redirects flush queued words and turn in-flight responses into discards.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_illegal,
   input  logic            inst_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int              CW         = $clog2(DEPTH + 1);
   localparam int              QW         = XLEN + 33;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   tag_count;
   logic [CW+1:0]   in_use;
   logic            q_full, q_empty, tag_full, tag_empty;
   logic [QW-1:0]   q_din, q_dout;
   logic [XLEN-1:0] tag_pc;
   logic            req_fire, rsp_drop, rsp_keep, q_push, q_pop;

   // Every interface transfers on a cycle where valid and ready are both high; valid never
   // depends on ready, except that a redirect suppresses a new request in its own cycle.
   assign in_use         = (CW+2)'(outstanding) + (CW+2)'(drop_cnt) + (CW+2)'(q_count);
   assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+2)'(DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
   assign q_push   = rsp_keep && !redirect_valid && !q_full;
   assign q_pop    = inst_valid && inst_ready;
   assign q_din    = {opc_illegal(imem_rsp_data[6:0]), tag_pc, imem_rsp_data};

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
      .clk   (clk),
      .rst   (rst),
      .push  (req_fire),
      .pop   (imem_rsp_valid),
      .flush (1'b0),
      .din   (pc),
      .dout  (tag_pc),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(QW)) u_fetch_q (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .pop   (q_pop),
      .flush (redirect_valid),
      .din   (q_din),
      .dout  (q_dout),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   // On redirect every still-unanswered request becomes a discard; a kept response
   // completing in the same cycle is no longer in flight, so it is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect_valid) begin
         pc          <= redirect_pc & ALIGN_MASK;
         outstanding <= '0;
         drop_cnt    <= drop_cnt - CW'(rsp_drop) + outstanding - CW'(rsp_keep);
      end else begin
         if (req_fire) pc <= pc + XLEN'(PC_INC);
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
         drop_cnt    <= drop_cnt - CW'(rsp_drop);
      end
   end

   assign inst_valid   = !q_empty;
   assign inst         = q_empty ? '0 : q_dout[31:0];
   assign inst_pc      = q_empty ? '0 : q_dout[XLEN+31:32];
   assign inst_illegal = !q_empty && q_dout[QW-1];

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(rsp_keep && q_full && !redirect_valid));
         assert (!(imem_rsp_valid && tag_empty));
         assert (!(req_fire && tag_full));
         assert (tag_count == outstanding + drop_cnt);
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against an in-order memory model
// and a program-order reference (next expected PC, re-targeted on every redirect).
module tb_instr_fetch_unit;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_illegal;
   logic        inst_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;

   instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_illegal   (inst_illegal),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] mem_q[$];
   int          mem_due[$];

   logic [31:0] exp_pc, exp_fetch;
   logic        drv_redirect = 1'b0, drv_ready = 1'b0, drv_req_ready = 1'b0, rsp_en = 1'b0;
   logic [31:0] drv_target = '0;
   int          n_req, n_dec, first_acc, first_val;
   logic [31:0] first_dec_pc, prev_req;
   logic        last_req_valid, wrap_seen, ill200, ill204;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [6:0] op;
      if (a == 32'h200) return 32'h0000_0013;
      if (a == 32'h204) return 32'h0000_0033;
      case (int'((a >> 2) % 32'd6))
         0:       op = 7'b0110011;
         1:       op = 7'b0000011;
         2:       op = 7'b0100011;
         3:       op = 7'b1100011;
         4:       op = 7'b0010011;
         default: op = 7'b1101111;
      endcase
      return {a[31:7] ^ 25'h15a5a5a, op};
   endfunction

   function automatic logic ref_illegal(input logic [31:0] w);
      return !(w[6:0] inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011});
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      check({tag, "_inst"}, inst, 32'd0);
      check({tag, "_inst_pc"}, inst_pc, 32'd0);
      check({tag, "_illegal"}, 32'(inst_illegal), 32'd0);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mem_q.delete(); mem_due.delete();
      exp_pc = RESET_PC; exp_fetch = RESET_PC;
      drv_redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero_outputs("reset");
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
   endtask

   // One clock: drive just after the edge, sample settled outputs, update the models.
   task automatic cycle();
      logic req_fire, dec_fire;
      #1;
      redirect_valid = drv_redirect;
      redirect_pc    = drv_target;
      inst_ready     = drv_ready;
      imem_req_ready = drv_req_ready;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (rsp_en && mem_q.size() > 0 && mem_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_q.pop_front());
         void'(mem_due.pop_front());
      end
      #1;
      req_fire       = imem_req_valid && imem_req_ready;
      dec_fire       = inst_valid && inst_ready;
      last_req_valid = imem_req_valid;
      if (drv_redirect) check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch);
      if (inst_valid && first_val < 0) first_val = cyc;
      if (req_fire) begin
         if (first_acc < 0) first_acc = cyc;
         if (imem_req_addr == 32'h0 && prev_req == 32'hFFFF_FFFC) wrap_seen = 1'b1;
         prev_req = imem_req_addr;
         mem_q.push_back(imem_req_addr);
         mem_due.push_back(cyc + 1);
         exp_fetch = exp_fetch + 32'd4;
         n_req++;
      end
      if (dec_fire) begin
         check("inst_pc", inst_pc, exp_pc);
         check("inst", inst, mem_word(exp_pc));
         check("inst_illegal", 32'(inst_illegal), 32'(ref_illegal(mem_word(exp_pc))));
         if (inst_pc == 32'h200) ill200 = inst_illegal;
         if (inst_pc == 32'h204) ill204 = inst_illegal;
         if (n_dec == 0) first_dec_pc = inst_pc;
         n_dec++;
         exp_pc = exp_pc + 32'd4;
      end
      if (drv_redirect) begin
         exp_pc    = drv_target & ~32'd3;
         exp_fetch = drv_target & ~32'd3;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect_to(input logic [31:0] t);
      drv_redirect = 1'b1; drv_target = t;
      cycle();
      drv_redirect = 1'b0;
   endtask

   initial begin
      prev_req = '0; wrap_seen = 1'b0; ill200 = 1'bx; ill204 = 1'bx;
      first_dec_pc = 'x; last_req_valid = 1'b0;
      do_reset();

      // Streaming from reset with a one-cycle memory
      drv_ready = 1; drv_req_ready = 1; rsp_en = 1;
      n_dec = 0; first_acc = -1; first_val = -1;
      run(8);
      check("first_latency", 32'(first_val - first_acc), 32'd2);
      check("stream_first_pc", first_dec_pc, RESET_PC);

      // Decode stalled: fetch stops at DEPTH words, then drains in order
      do_reset();
      drv_ready = 0; n_req = 0;
      run(10);
      check("stall_req_count", 32'(n_req), 32'(DEPTH));
      check("stall_req_valid", 32'(last_req_valid), 32'd0);
      drv_ready = 1; n_dec = 0;
      run(10);
      check("stall_first_pc", first_dec_pc, 32'h0);
      check("stall_drained", 32'(n_dec >= 2), 32'd1);

      // Redirect with two requests in flight
      do_reset();
      rsp_en = 0; n_req = 0;
      run(3);
      check("inflight_count", 32'(n_req), 32'd2);
      redirect_to(32'h100);
      rsp_en = 1; n_dec = 0;
      run(12);
      check("redirect_target", first_dec_pc, 32'h100);

      // Unaligned target and opcode legality
      redirect_to(32'h203);
      n_dec = 0;
      run(12);
      check("illegal_0x13", 32'(ill200), 32'd1);
      check("legal_0x33", 32'(ill204), 32'd0);

      // Back-to-back redirects, last wins
      redirect_to(32'h300);
      redirect_to(32'h400);
      n_dec = 0;
      run(10);
      check("b2b_redirect", first_dec_pc, 32'h400);

      // PC wrap
      redirect_to(32'hFFFF_FFFC);
      run(12);
      check("pc_wrap", 32'(wrap_seen), 32'd1);

      // Randomized traffic
      n_dec = 0;
      for (int i = 0; i < 500; i++) begin
         drv_ready     = ($urandom_range(0, 3) != 0);
         drv_req_ready = ($urandom_range(0, 3) != 0);
         rsp_en        = ($urandom_range(0, 2) != 0);
         drv_target    = $urandom();
         drv_redirect  = ($urandom_range(0, 14) == 0);
         cycle();
      end
      drv_redirect = 0; drv_ready = 1; drv_req_ready = 1; rsp_en = 1;
      run(10);
      check("random_progress", 32'(n_dec > 50), 32'd1);

      // Asynchronous reset in the middle of a burst
      run(6);
      #3 rst = 1'b1;
      #1 check_zero_outputs("async_reset");
      do_reset();
      n_dec = 0;
      run(8);
      check("restart_pc", first_dec_pc, RESET_PC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
